execution_unit_param: RTL and testbench

Parametrised successor to the 8-bit execution unit. It executes one ALU, multiply or divide operation per start/busy/done transaction at a configurable operand width. Multiply uses an iterative shift-add datapath and divide uses an iterative restoring datapath, each retiring one bit per cycle. Compared with the 8-bit unit it adds a synchronous reset, a remainder output, an error flag for divide-by-zero and illegal opcodes, and back-to-back issue.

---
 rtl/execution_unit_param.sv | 173 +++++++++++++++++
 tb/tb_execution_unit_param.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/execution_unit_param.sv
// rtl/execution_unit_param.sv - parametrised ALU / shift-add multiply / restoring divide unit
module execution_unit_param #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           opcode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   result,
    output logic [WIDTH-1:0]     remainder,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;

    typedef enum logic [2:0] {S_IDLE, S_ALU, S_MUL, S_DIV, S_DONE} state_t;

    state_t               state;
    logic [3:0]           op_r;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [CNT_W-1:0]     cnt;

    logic [2*WIDTH-1:0]   mul_acc;
    logic [2*WIDTH-1:0]   mul_mcand;
    logic [WIDTH-1:0]     mul_mplier;
    logic [2*WIDTH-1:0]   mul_acc_nxt;

    logic [WIDTH-1:0]     div_rem;
    logic [WIDTH-1:0]     div_q;
    logic [WIDTH:0]       div_shift;
    logic                 div_ok;
    logic [WIDTH-1:0]     div_rem_nxt;
    logic [WIDTH-1:0]     div_q_nxt;

    logic [2*WIDTH-1:0]   alu_res;
    logic                 alu_ill;
    logic [WIDTH:0]       alu_sum;

    wire last_step = (cnt == CNT_W'(WIDTH - 1));

    // Single-cycle ALU result from the latched operands; illegal codes yield zero
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        alu_sum = {1'b0, a_r} + {1'b0, b_r};
        case (op_r)
            OP_ADD:  alu_res = {{(WIDTH-1){1'b0}}, alu_sum};
            OP_SUB:  alu_res = {{WIDTH{1'b0}}, a_r - b_r};
            OP_AND:  alu_res = {{WIDTH{1'b0}}, a_r & b_r};
            OP_OR:   alu_res = {{WIDTH{1'b0}}, a_r | b_r};
            OP_XOR:  alu_res = {{WIDTH{1'b0}}, a_r ^ b_r};
            OP_NOT:  alu_res = {{WIDTH{1'b0}}, ~a_r};
            default: alu_ill = 1'b1;
        endcase
    end

    // One shift-add multiply step and one restoring divide step per cycle
    always_comb begin
        mul_acc_nxt = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
        div_shift   = {div_rem, div_q[WIDTH-1]};
        div_ok      = (div_shift >= {1'b0, b_r});
        div_rem_nxt = WIDTH'(div_ok ? (div_shift - {1'b0, b_r}) : div_shift);
        div_q_nxt   = {div_q[WIDTH-2:0], div_ok};
    end

    // Control FSM with registered outputs; DONE doubles as an accept point for back-to-back issue
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            op_r       <= '0;
            a_r        <= '0;
            b_r        <= '0;
            cnt        <= '0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            div_rem    <= '0;
            div_q      <= '0;
            result     <= '0;
            remainder  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_r       <= opcode;
                        a_r        <= A;
                        b_r        <= B;
                        cnt        <= '0;
                        mul_acc    <= '0;
                        mul_mcand  <= {{WIDTH{1'b0}}, A};
                        mul_mplier <= B;
                        div_rem    <= '0;
                        div_q      <= A;
                        busy       <= 1'b1;
                        if (opcode == OP_MUL)      state <= S_MUL;
                        else if (opcode == OP_DIV) state <= S_DIV;
                        else                       state <= S_ALU;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ALU: begin
                    result    <= alu_res;
                    remainder <= '0;
                    err       <= alu_ill;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= S_DONE;
                end
                S_MUL: begin
                    mul_acc    <= mul_acc_nxt;
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    cnt        <= cnt + 1'b1;
                    if (last_step) begin
                        result    <= mul_acc_nxt;
                        remainder <= '0;
                        err       <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (b_r == '0) begin
                        // Divide-by-zero: saturated quotient, dividend passed through as remainder
                        result    <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                        remainder <= a_r;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        div_rem <= div_rem_nxt;
                        div_q   <= div_q_nxt;
                        cnt     <= cnt + 1'b1;
                        if (last_step) begin
                            result    <= {{WIDTH{1'b0}}, div_q_nxt};
                            remainder <= div_rem_nxt;
                            err       <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_execution_unit_param.sv
// tb/tb_execution_unit_param.sv - randomized self-checking bench for execution_unit_param
module tb_execution_unit_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8, start8, busy8, done8, err8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, rem8;
    logic [15:0] res8;

    logic        rst16, start16, busy16, done16, err16;
    logic [3:0]  op16;
    logic [15:0] a16, b16, rem16;
    logic [31:0] res16;

    int checks = 0;
    int errors = 0;

    longint last_res8 = 0;
    longint last_rem8 = 0;
    bit     last_err8 = 0;

    execution_unit_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .opcode(op8), .A(a8), .B(b8),
        .result(res8), .remainder(rem8), .busy(busy8), .done(done8), .err(err8)
    );

    execution_unit_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst16), .start(start16), .opcode(op16), .A(a16), .B(b16),
        .result(res16), .remainder(rem16), .busy(busy16), .done(done16), .err(err16)
    );

    function automatic void model(input int w, input logic [3:0] op, input longint a, input longint b,
                                  output longint res, output longint rem, output bit e, output int lat);
        longint m;
        m   = (longint'(1) << w) - 1;
        res = 0; rem = 0; e = 0; lat = 1;
        case (op)
            4'd0: res = a + b;
            4'd1: res = (a - b) & m;
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = (~a) & m;
            4'd8: begin res = a * b; lat = w; end
            4'd9: begin
                if (b == 0) begin res = m; rem = a; e = 1; end
                else begin res = a / b; rem = a % b; lat = w; end
            end
            default: e = 1;
        endcase
    endfunction

    task automatic do_op8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input bit toggle, input string name);
        longint er, erem;
        bit     ee, busy_ok;
        int     lat, edges;
        model(8, op, longint'(a), longint'(b), er, erem, ee, lat);
        @(negedge clk);
        start8 = 1'b1; op8 = op; a8 = a; b8 = b;
        @(negedge clk);
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0 || res8 !== 16'(last_res8) || rem8 !== 8'(last_rem8) || err8 !== last_err8) begin
            errors++;
            $display("FAIL %s accept: busy=%b done=%b result=%h rem=%h err=%b, required busy=1 done=0 result=%h rem=%h err=%b",
                     name, busy8, done8, res8, rem8, err8, 16'(last_res8), 8'(last_rem8), last_err8);
        end
        edges = 0; busy_ok = 1;
        while (done8 !== 1'b1 && edges < 100) begin
            if (busy8 !== 1'b1) busy_ok = 0;
            if (toggle) begin a8 = 8'($urandom); b8 = 8'($urandom); op8 = 4'($urandom); end
            @(negedge clk);
            edges++;
        end
        checks++;
        if (edges != lat) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, required %0d", name, edges, lat);
        end
        checks++;
        if (busy8 !== 1'b0 || !busy_ok) begin
            errors++;
            $display("FAIL %s busy: busy at done=%b busy held=%b, required 0 and 1", name, busy8, busy_ok);
        end
        checks++;
        if (res8 !== 16'(er) || rem8 !== 8'(erem) || err8 !== ee) begin
            errors++;
            $display("FAIL %s value: result=%h rem=%h err=%b, required result=%h rem=%h err=%b",
                     name, res8, rem8, err8, 16'(er), 8'(erem), ee);
        end
        last_res8 = er; last_rem8 = erem; last_err8 = ee;
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: done=%b one cycle later, required 0", name, done8);
        end
    endtask

    task automatic test_reset();
        rst8 = 1'b1; rst16 = 1'b1; start8 = 1'b0; start16 = 1'b0;
        op8 = '0; a8 = '0; b8 = '0; op16 = '0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        rst8 = 1'b0; rst16 = 1'b0;
        @(negedge clk);
        checks++;
        if (res8 !== 16'h0 || rem8 !== 8'h0 || busy8 !== 1'b0 || done8 !== 1'b0 || err8 !== 1'b0) begin
            errors++;
            $display("FAIL reset8: result=%h rem=%h busy=%b done=%b err=%b, required all 0", res8, rem8, busy8, done8, err8);
        end
        checks++;
        if (res16 !== 32'h0 || rem16 !== 16'h0 || busy16 !== 1'b0 || done16 !== 1'b0 || err16 !== 1'b0) begin
            errors++;
            $display("FAIL reset16: result=%h rem=%h busy=%b done=%b err=%b, required all 0", res16, rem16, busy16, done16, err16);
        end
    endtask

    task automatic test_directed();
        do_op8(4'b0000, 8'd200, 8'd100, 0, "add_200_100");
        do_op8(4'b1000, 8'd255, 8'd255, 1, "mul_255_255_toggle");
        do_op8(4'b1001, 8'd20,  8'd4,   0, "div_20_4");
        do_op8(4'b1001, 8'd7,   8'd9,   0, "div_a_lt_b");
        do_op8(4'b1001, 8'd9,   8'd0,   0, "div_by_zero");
        do_op8(4'b1100, 8'd3,   8'd4,   0, "illegal_1100");
        do_op8(4'b0100, 8'hAA,  8'hCC,  0, "xor_clears_err");
        do_op8(4'b0101, 8'hAA,  8'h00,  0, "not_aa");
        do_op8(4'b0001, 8'd5,   8'd7,   0, "sub_wrap");
        do_op8(4'b1001, 8'd9,   8'd9,   1, "div_a_eq_b");
        do_op8(4'b1001, 8'd255, 8'd1,   0, "div_by_one");
        do_op8(4'b0000, 8'd255, 8'd255, 0, "add_carry");
        do_op8(4'b0011, 8'h0F,  8'hF0,  0, "or");
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [7:0] a, b;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            if (i % 3 == 0) op = ($urandom_range(0, 1) != 0) ? 4'b1000 : 4'b1001;
            a = 8'($urandom);
            b = 8'($urandom);
            if (op == 4'b1001 && $urandom_range(0, 4) == 0) b = 8'h00;
            do_op8(op, a, b, bit'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_back_to_back();
        int edges, extra;
        @(negedge clk);
        start8 = 1'b1; op8 = 4'b1000; a8 = 8'd255; b8 = 8'd255;
        @(negedge clk);
        op8 = 4'b0010; a8 = 8'hAA; b8 = 8'hCC;
        edges = 0;
        while (done8 !== 1'b1 && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        checks++;
        if (edges != 8 || res8 !== 16'hFE01) begin
            errors++;
            $display("FAIL b2b_mul: edges=%0d result=%h, required 8 and fe01", edges, res8);
        end
        @(negedge clk);
        start8 = 1'b0;
        checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: done=%b busy=%b, required done=0 busy=1", done8, busy8);
        end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b1 || busy8 !== 1'b0 || res8 !== 16'h0088 || err8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_and: done=%b busy=%b result=%h err=%b, required 1 0 0088 0", done8, busy8, res8, err8);
        end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL b2b_idle: %0d cycles with done/busy, required 0", extra);
        end
        last_res8 = 16'h0088; last_rem8 = 0; last_err8 = 0;
    endtask

    task automatic test_width16();
        int busy_cycles, edges, seen;
        longint a, b;
        @(negedge clk);
        start16 = 1'b1; op16 = 4'b1000; a16 = 16'd1000; b16 = 16'd3000;
        @(negedge clk);
        start16 = 1'b0;
        busy_cycles = 0; edges = 0;
        while (done16 !== 1'b1 && edges < 100) begin
            if (busy16 === 1'b1) busy_cycles++;
            a16 = 16'($urandom); b16 = 16'($urandom);
            @(negedge clk);
            edges++;
        end
        checks++;
        if (busy_cycles != 16 || edges != 16 || res16 !== 32'd3000000 || err16 !== 1'b0) begin
            errors++;
            $display("FAIL w16_mul: busy=%0d edges=%0d result=%0d, required 16 16 3000000", busy_cycles, edges, res16);
        end
        a = longint'($urandom_range(1, 65535));
        b = longint'($urandom_range(1, 255));
        @(negedge clk);
        start16 = 1'b1; op16 = 4'b1001; a16 = 16'(a); b16 = 16'(b);
        @(negedge clk);
        start16 = 1'b0;
        edges = 0;
        while (done16 !== 1'b1 && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        checks++;
        if (edges != 16 || res16 !== 32'(a / b) || rem16 !== 16'(a % b)) begin
            errors++;
            $display("FAIL w16_div: edges=%0d q=%0d r=%0d, required 16 %0d %0d", edges, res16, rem16, a / b, a % b);
        end
        @(negedge clk);
        start16 = 1'b1; op16 = 4'b1001; a16 = 16'd50000; b16 = 16'd7;
        @(negedge clk);
        start16 = 1'b0;
        repeat (5) @(negedge clk);
        rst16 = 1'b1;
        @(negedge clk);
        rst16 = 1'b0;
        checks++;
        if (busy16 !== 1'b0 || done16 !== 1'b0 || res16 !== 32'h0 || rem16 !== 16'h0 || err16 !== 1'b0) begin
            errors++;
            $display("FAIL w16_reset_mid_div: busy=%b done=%b result=%h rem=%h err=%b, required all 0",
                     busy16, done16, res16, rem16, err16);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done16 === 1'b1 || busy16 === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL w16_no_done_after_abort: %0d active cycles, required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_width16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
